// File: rtl/m_ps2_keydecode.sv
// m_ps2_keydecode
// Turns a PS/2 scan-code set 2 byte stream into key events and queues them
// in a show-ahead FIFO for the virtio keyboard model.
// Prefix and break bytes, the Pause sequence, controller status bytes and
// typematic repeats are absorbed here. The consumer therefore sees exactly
// one 16-bit word per real key transition.
//
// Ports
//   CLK, RST_X   clock; asynchronous active-low reset
//   w_rx_en      one-cycle strobe, w_rx_data holds a received byte
//   w_rx_data    received scan-code byte
//   w_flush      synchronous clear of FIFO, decoder, held-key map, drop count
//   w_ev_valid   FIFO non-empty
//   w_ev_ready   consumer pops the head
//   w_ev_data    head event {8'h01 press / 8'h00 release, keycode}
//   w_ev_cnt     FIFO occupancy
//   w_drop_cnt   saturating count of events lost to a full FIFO
//   w_dbg_state  decoder state (state_t encoding)
//
// Handshake: an event leaves the FIFO on every rising edge where w_ev_valid
// and w_ev_ready are both high. w_ev_data is stable while w_ev_valid is high
// and no pop has happened.
module m_ps2_keydecode #(
    parameter int FIFO_DEPTH      = 8,
    parameter int TIMEOUT_CYC     = 1000000,
    parameter bit SUPPRESS_REPEAT = 1'b1
) (
    input  logic                        CLK,
    input  logic                        RST_X,
    input  logic                        w_rx_en,
    input  logic [7:0]                  w_rx_data,
    input  logic                        w_flush,
    output logic                        w_ev_valid,
    input  logic                        w_ev_ready,
    output logic [15:0]                 w_ev_data,
    output logic [$clog2(FIFO_DEPTH):0] w_ev_cnt,
    output logic [7:0]                  w_drop_cnt,
    output logic [2:0]                  w_dbg_state
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_EXT = 3'd1, S_BRK = 3'd2,
        S_EXTBRK = 3'd3, S_PAUSE = 3'd4, S_PREL = 3'd5
    } state_t;

    localparam logic [7:0] KEY_PAUSE = 8'd119;

    function automatic logic [7:0] norm_key(input logic [7:0] b);
        logic [7:0] k;
        case (b)
            8'h76: k = 8'd1;   8'h16: k = 8'd2;   8'h1E: k = 8'd3;   8'h26: k = 8'd4;
            8'h25: k = 8'd5;   8'h2E: k = 8'd6;   8'h36: k = 8'd7;   8'h3D: k = 8'd8;
            8'h3E: k = 8'd9;   8'h46: k = 8'd10;  8'h45: k = 8'd11;  8'h4E: k = 8'd12;
            8'h55: k = 8'd13;  8'h66: k = 8'd14;  8'h0D: k = 8'd15;  8'h15: k = 8'd16;
            8'h1D: k = 8'd17;  8'h24: k = 8'd18;  8'h2D: k = 8'd19;  8'h2C: k = 8'd20;
            8'h35: k = 8'd21;  8'h3C: k = 8'd22;  8'h43: k = 8'd23;  8'h44: k = 8'd24;
            8'h4D: k = 8'd25;  8'h54: k = 8'd26;  8'h5B: k = 8'd27;  8'h5A: k = 8'd28;
            8'h14: k = 8'd29;  8'h1C: k = 8'd30;  8'h1B: k = 8'd31;  8'h23: k = 8'd32;
            8'h2B: k = 8'd33;  8'h34: k = 8'd34;  8'h33: k = 8'd35;  8'h3B: k = 8'd36;
            8'h42: k = 8'd37;  8'h4B: k = 8'd38;  8'h4C: k = 8'd39;  8'h52: k = 8'd40;
            8'h0E: k = 8'd41;  8'h12: k = 8'd42;  8'h5D: k = 8'd43;  8'h1A: k = 8'd44;
            8'h22: k = 8'd45;  8'h21: k = 8'd46;  8'h2A: k = 8'd47;  8'h32: k = 8'd48;
            8'h31: k = 8'd49;  8'h3A: k = 8'd50;  8'h41: k = 8'd51;  8'h49: k = 8'd52;
            8'h4A: k = 8'd53;  8'h59: k = 8'd54;  8'h7C: k = 8'd55;  8'h11: k = 8'd56;
            8'h29: k = 8'd57;  8'h58: k = 8'd58;  8'h05: k = 8'd59;  8'h06: k = 8'd60;
            8'h04: k = 8'd61;  8'h0C: k = 8'd62;  8'h03: k = 8'd63;  8'h0B: k = 8'd64;
            8'h83: k = 8'd65;  8'h0A: k = 8'd66;  8'h01: k = 8'd67;  8'h09: k = 8'd68;
            8'h77: k = 8'd69;  8'h7E: k = 8'd70;  8'h6C: k = 8'd71;  8'h75: k = 8'd72;
            8'h7D: k = 8'd73;  8'h7B: k = 8'd74;  8'h6B: k = 8'd75;  8'h73: k = 8'd76;
            8'h74: k = 8'd77;  8'h79: k = 8'd78;  8'h69: k = 8'd79;  8'h72: k = 8'd80;
            8'h7A: k = 8'd81;  8'h70: k = 8'd82;  8'h71: k = 8'd83;  8'h61: k = 8'd86;
            8'h78: k = 8'd87;  8'h07: k = 8'd88;
            default: k = 8'd0;
        endcase
        return k;
    endfunction

    // E0 12 / E0 59 (fake shifts) are deliberately absent and map to 0.
    function automatic logic [7:0] ext_key(input logic [7:0] b);
        logic [7:0] k;
        case (b)
            8'h75: k = 8'd103; 8'h72: k = 8'd108; 8'h6B: k = 8'd105; 8'h74: k = 8'd106;
            8'h14: k = 8'd97;  8'h11: k = 8'd100; 8'h7C: k = 8'd99;  8'h71: k = 8'd111;
            8'h6C: k = 8'd102; 8'h69: k = 8'd107; 8'h7D: k = 8'd104; 8'h7A: k = 8'd109;
            8'h70: k = 8'd110; 8'h4A: k = 8'd98;  8'h5A: k = 8'd96;  8'h1F: k = 8'd125;
            8'h27: k = 8'd126; 8'h2F: k = 8'd127;
            default: k = 8'd0;
        endcase
        return k;
    endfunction

    state_t          state_q, state_d;
    logic [2:0]      skip_q, skip_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            pend_v_q, pend_v_d;
    logic [15:0]     pend_q, pend_d;
    logic [255:0]    held_q, held_d;
    logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      drop_q, drop_d;
    logic [15:0]     mem_q [FIFO_DEPTH];
    logic            ev_ok, push, pop, full;
    logic [7:0]      ev_key;

    // Stage 1: byte decoder. A completed sequence lands in pend_q and is
    // committed to the FIFO on the following edge.
    always_comb begin
        state_d  = state_q;
        skip_d   = skip_q;
        tmo_d    = '0;
        pend_v_d = 1'b0;
        pend_d   = pend_q;
        case (state_q)
            S_IDLE: if (w_rx_en) begin
                case (w_rx_data)
                    8'hE0: state_d = S_EXT;
                    8'hF0: state_d = S_BRK;
                    8'hE1: begin state_d = S_PAUSE; skip_d = 3'd7; end
                    8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: state_d = S_IDLE;
                    default: begin pend_v_d = 1'b1; pend_d = {8'h01, norm_key(w_rx_data)}; end
                endcase
            end
            S_EXT: if (w_rx_en) begin
                if (w_rx_data == 8'hF0) begin
                    state_d = S_EXTBRK;
                end else begin
                    pend_v_d = 1'b1; pend_d = {8'h01, ext_key(w_rx_data)}; state_d = S_IDLE;
                end
            end
            S_BRK: if (w_rx_en) begin
                pend_v_d = 1'b1; pend_d = {8'h00, norm_key(w_rx_data)}; state_d = S_IDLE;
            end
            S_EXTBRK: if (w_rx_en) begin
                pend_v_d = 1'b1; pend_d = {8'h00, ext_key(w_rx_data)}; state_d = S_IDLE;
            end
            S_PAUSE: if (w_rx_en) begin
                if (skip_q == 3'd1) begin
                    pend_v_d = 1'b1; pend_d = {8'h01, KEY_PAUSE}; state_d = S_PREL;
                end
                skip_d = skip_q - 3'd1;
            end
            S_PREL: begin
                pend_v_d = 1'b1; pend_d = {8'h00, KEY_PAUSE}; state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Idle-time watchdog for half-received multi-byte sequences.
        if (state_q inside {S_EXT, S_BRK, S_EXTBRK, S_PAUSE} && !w_rx_en) begin
            if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                state_d = S_IDLE;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
        if (w_flush) begin
            state_d  = S_IDLE;
            skip_d   = '0;
            tmo_d    = '0;
            pend_v_d = 1'b0;
        end
    end

    // Stage 2: key-map filter and FIFO.
    always_comb begin
        ev_key = pend_q[7:0];
        ev_ok  = pend_v_q && (ev_key != 8'd0) &&
                 !(SUPPRESS_REPEAT && pend_q[8] && held_q[ev_key]);
        pop    = (cnt_q != '0) && w_ev_ready;
        full   = (cnt_q == CW'(FIFO_DEPTH));
        // A pop on the same edge frees the slot, so a full FIFO still accepts.
        push   = ev_ok && (!full || pop);
        held_d = held_q;
        drop_d = drop_q;
        // The map follows the keyboard even when the event itself is dropped.
        if (ev_ok) held_d[ev_key] = pend_q[8];
        if (ev_ok && !push && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        wr_d  = push ? wr_q + AW'(1) : wr_q;
        rd_d  = pop  ? rd_q + AW'(1) : rd_q;
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        if (w_flush) begin
            held_d = '0;
            drop_d = '0;
            wr_d   = '0;
            rd_d   = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q  <= S_IDLE;
            skip_q   <= '0;
            tmo_q    <= '0;
            pend_v_q <= 1'b0;
            pend_q   <= '0;
            held_q   <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            skip_q   <= skip_d;
            tmo_q    <= tmo_d;
            pend_v_q <= pend_v_d;
            pend_q   <= pend_d;
            held_q   <= held_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            drop_q   <= drop_d;
        end
    end

    // Storage needs no reset: the head is only visible while cnt_q is non-zero.
    always_ff @(posedge CLK) begin
        if (push && !w_flush) mem_q[wr_q] <= pend_q;
    end

    assign w_ev_valid  = (cnt_q != '0);
    assign w_ev_data   = w_ev_valid ? mem_q[rd_q] : 16'h0000;
    assign w_ev_cnt    = cnt_q;
    assign w_drop_cnt  = drop_q;
    assign w_dbg_state = state_q;
endmodule

// File: tb/tb_m_ps2_keydecode.sv
module tb_m_ps2_keydecode;
    logic        clk = 1'b0;
    logic        rst_x = 1'b0;
    logic        rx_en = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        flush = 1'b0;
    logic        ready = 1'b0;
    logic        ready_nr = 1'b0;
    logic        ev_valid, ev_valid_nr;
    logic [15:0] ev_data, ev_data_nr;
    logic [3:0]  ev_cnt, ev_cnt_nr;
    logic [7:0]  drop_cnt, drop_cnt_nr;
    logic [2:0]  dbg_state, dbg_state_nr;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Main instance: repeat suppression on, short timeout.
    m_ps2_keydecode #(.FIFO_DEPTH(8), .TIMEOUT_CYC(20), .SUPPRESS_REPEAT(1'b1)) u_dut (
        .CLK(clk), .RST_X(rst_x), .w_rx_en(rx_en), .w_rx_data(rx_data), .w_flush(flush),
        .w_ev_valid(ev_valid), .w_ev_ready(ready), .w_ev_data(ev_data),
        .w_ev_cnt(ev_cnt), .w_drop_cnt(drop_cnt), .w_dbg_state(dbg_state)
    );

    // Companion instance with repeat suppression off, fed the same bytes.
    m_ps2_keydecode #(.FIFO_DEPTH(8), .TIMEOUT_CYC(20), .SUPPRESS_REPEAT(1'b0)) u_dut_nr (
        .CLK(clk), .RST_X(rst_x), .w_rx_en(rx_en), .w_rx_data(rx_data), .w_flush(flush),
        .w_ev_valid(ev_valid_nr), .w_ev_ready(ready_nr), .w_ev_data(ev_data_nr),
        .w_ev_cnt(ev_cnt_nr), .w_drop_cnt(drop_cnt_nr), .w_dbg_state(dbg_state_nr)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_en   = 1'b1;
        rx_data = b;
        @(posedge clk);
        #1;
        rx_en   = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    // Waits (bounded) for an event, captures the head and pops it.
    task automatic pop_ev(output logic [15:0] d, output bit ok);
        int n = 0;
        while (!ev_valid && n < 20) begin
            tick(1);
            n++;
        end
        ok = ev_valid;
        d  = ev_data;
        if (ok) begin
            ready = 1'b1;
            @(posedge clk);
            #1;
            ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_x = 1'b0;
        tick(3);
        total_cnt++; if (ev_valid !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", ev_valid); else pass_cnt++;
        total_cnt++; if (ev_cnt !== 4'd0) $display("FAIL reset_cnt got=%0d exp=0", ev_cnt); else pass_cnt++;
        total_cnt++; if (drop_cnt !== 8'd0) $display("FAIL reset_drop got=%0d exp=0", drop_cnt); else pass_cnt++;
        total_cnt++; if (ev_data !== 16'h0000) $display("FAIL reset_data got=%h exp=0000", ev_data); else pass_cnt++;
        total_cnt++; if (dbg_state !== 3'd0) $display("FAIL reset_state got=%0d exp=0", dbg_state); else pass_cnt++;
        rst_x = 1'b1;
        tick(1);
    endtask

    task automatic test_make_break();
        logic [15:0] d;
        bit ok;
        send_byte(8'h1C);
        total_cnt++; if (ev_valid !== 1'b0) $display("FAIL mb_latency_early got=%0b exp=0", ev_valid); else pass_cnt++;
        tick(1);
        total_cnt++; if (ev_valid !== 1'b1 || ev_data !== 16'h011E)
            $display("FAIL mb_first_event got=%0b/%h exp=1/011e", ev_valid, ev_data); else pass_cnt++;
        send_byte(8'hF0);
        send_byte(8'h1C);
        tick(1);
        total_cnt++; if (ev_cnt !== 4'd2) $display("FAIL mb_cnt got=%0d exp=2", ev_cnt); else pass_cnt++;
        pop_ev(d, ok);
        total_cnt++; if (!ok || d !== 16'h011E) $display("FAIL mb_press got=%h exp=011e", d); else pass_cnt++;
        pop_ev(d, ok);
        total_cnt++; if (!ok || d !== 16'h001E) $display("FAIL mb_release got=%h exp=001e", d); else pass_cnt++;
        total_cnt++; if (ev_cnt !== 4'd0) $display("FAIL mb_empty got=%0d exp=0", ev_cnt); else pass_cnt++;
    endtask

    task automatic test_extended();
        logic [15:0] d;
        bit ok;
        send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        tick(1);
        total_cnt++; if (ev_cnt !== 4'd2) $display("FAIL ext_cnt got=%0d exp=2", ev_cnt); else pass_cnt++;
        pop_ev(d, ok);
        total_cnt++; if (!ok || d !== 16'h0167) $display("FAIL ext_up_press got=%h exp=0167", d); else pass_cnt++;
        pop_ev(d, ok);
        total_cnt++; if (!ok || d !== 16'h0067) $display("FAIL ext_up_release got=%h exp=0067", d); else pass_cnt++;
        send_byte(8'hE0); send_byte(8'h12);
        send_byte(8'hE0); send_byte(8'h7C);
        tick(1);
        total_cnt++; if (ev_cnt !== 4'd1) $display("FAIL fake_shift_cnt got=%0d exp=1", ev_cnt); else pass_cnt++;
        pop_ev(d, ok);
        total_cnt++; if (!ok || d !== 16'h0163) $display("FAIL prtsc_press got=%h exp=0163", d); else pass_cnt++;
    endtask

    task automatic test_pause();
        logic [15:0] d;
        bit ok;
        send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
        send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
        total_cnt++; if (ev_cnt !== 4'd0) $display("FAIL pause_early got=%0d exp=0", ev_cnt); else pass_cnt++;
        tick(1);
        total_cnt++; if (ev_cnt !== 4'd1 || ev_data !== 16'h0177)
            $display("FAIL pause_press got=%0d/%h exp=1/0177", ev_cnt, ev_data); else pass_cnt++;
        tick(1);
        total_cnt++; if (ev_cnt !== 4'd2) $display("FAIL pause_release_next got=%0d exp=2", ev_cnt); else pass_cnt++;
        total_cnt++; if (dbg_state !== 3'd0) $display("FAIL pause_idle got=%0d exp=0", dbg_state); else pass_cnt++;
        pop_ev(d, ok);
        total_cnt++; if (!ok || d !== 16'h0177) $display("FAIL pause_pop1 got=%h exp=0177", d); else pass_cnt++;
        pop_ev(d, ok);
        total_cnt++; if (!ok || d !== 16'h0077) $display("FAIL pause_pop2 got=%h exp=0077", d); else pass_cnt++;
    endtask

    task automatic test_repeat();
        logic [15:0] d;
        bit ok;
        do_flush();
        send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
        send_byte(8'hF0); send_byte(8'h1C);
        tick(2);
        total_cnt++; if (ev_cnt !== 4'd2) $display("FAIL rep_suppr_cnt got=%0d exp=2", ev_cnt); else pass_cnt++;
        total_cnt++; if (ev_cnt_nr !== 4'd4) $display("FAIL rep_nosuppr_cnt got=%0d exp=4", ev_cnt_nr); else pass_cnt++;
        total_cnt++; if (drop_cnt !== 8'd0) $display("FAIL rep_no_drop got=%0d exp=0", drop_cnt); else pass_cnt++;
        pop_ev(d, ok);
        total_cnt++; if (!ok || d !== 16'h011E) $display("FAIL rep_press got=%h exp=011e", d); else pass_cnt++;
        pop_ev(d, ok);
        total_cnt++; if (!ok || d !== 16'h001E) $display("FAIL rep_release got=%h exp=001e", d); else pass_cnt++;
        ready_nr = 1'b1;
        tick(4);
        ready_nr = 1'b0;
        total_cnt++; if (ev_cnt_nr !== 4'd0) $display("FAIL rep_nr_drained got=%0d exp=0", ev_cnt_nr); else pass_cnt++;
    endtask

    // Back-to-back bytes every cycle into a FIFO that nobody drains.
    task automatic test_back_to_back_full();
        logic [7:0] codes [10] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42, 8'h4B, 8'h15};
        logic [15:0] d;
        bit ok;
        do_flush();
        for (int i = 0; i < 10; i++) send_byte(codes[i]);
        tick(1);
        total_cnt++; if (ev_cnt !== 4'd8) $display("FAIL full_cnt got=%0d exp=8", ev_cnt); else pass_cnt++;
        total_cnt++; if (drop_cnt !== 8'd2) $display("FAIL full_drop got=%0d exp=2", drop_cnt); else pass_cnt++;
        total_cnt++; if (ev_data !== 16'h011E) $display("FAIL full_head got=%h exp=011e", ev_data); else pass_cnt++;
        send_byte(8'h1A);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        total_cnt++; if (ev_cnt !== 4'd8) $display("FAIL full_pushpop_cnt got=%0d exp=8", ev_cnt); else pass_cnt++;
        total_cnt++; if (drop_cnt !== 8'd2) $display("FAIL full_pushpop_drop got=%0d exp=2", drop_cnt); else pass_cnt++;
        total_cnt++; if (ev_data !== 16'h011F) $display("FAIL full_pushpop_head got=%h exp=011f", ev_data); else pass_cnt++;
        for (int i = 0; i < 8; i++) pop_ev(d, ok);
        total_cnt++; if (!ok || d !== 16'h012C) $display("FAIL full_tail got=%h exp=012c", d); else pass_cnt++;
        total_cnt++; if (ev_cnt !== 4'd0) $display("FAIL full_drained got=%0d exp=0", ev_cnt); else pass_cnt++;
    endtask

    task automatic test_timeout();
        logic [15:0] d;
        bit ok;
        do_flush();
        total_cnt++; if (drop_cnt !== 8'd0) $display("FAIL flush_drop got=%0d exp=0", drop_cnt); else pass_cnt++;
        send_byte(8'hE0);
        tick(25);
        total_cnt++; if (dbg_state !== 3'd0) $display("FAIL tmo_idle got=%0d exp=0", dbg_state); else pass_cnt++;
        send_byte(8'h1C);
        tick(1);
        pop_ev(d, ok);
        total_cnt++; if (!ok || d !== 16'h011E) $display("FAIL tmo_normal got=%h exp=011e", d); else pass_cnt++;
        send_byte(8'hE0);
        tick(5);
        total_cnt++; if (dbg_state !== 3'd1) $display("FAIL tmo_still_ext got=%0d exp=1", dbg_state); else pass_cnt++;
        send_byte(8'h75);
        tick(1);
        pop_ev(d, ok);
        total_cnt++; if (!ok || d !== 16'h0167) $display("FAIL tmo_ext_kept got=%h exp=0167", d); else pass_cnt++;
    endtask

    task automatic test_flush_mid();
        logic [15:0] d;
        bit ok;
        send_byte(8'hE0);
        send_byte(8'hF0);
        total_cnt++; if (dbg_state !== 3'd3) $display("FAIL fl_extbrk got=%0d exp=3", dbg_state); else pass_cnt++;
        do_flush();
        total_cnt++; if (dbg_state !== 3'd0 || ev_valid !== 1'b0)
            $display("FAIL fl_mid got=%0d/%0b exp=0/0", dbg_state, ev_valid); else pass_cnt++;
        send_byte(8'h75);
        tick(1);
        pop_ev(d, ok);
        total_cnt++; if (!ok || d !== 16'h0148) $display("FAIL fl_after got=%h exp=0148", d); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [15:0] d;
        bit ok;
        send_byte(8'hE0);
        total_cnt++; if (dbg_state !== 3'd1) $display("FAIL rs_ext got=%0d exp=1", dbg_state); else pass_cnt++;
        rst_x = 1'b0;
        #2;
        total_cnt++; if (dbg_state !== 3'd0 || ev_valid !== 1'b0)
            $display("FAIL rs_mid got=%0d/%0b exp=0/0", dbg_state, ev_valid); else pass_cnt++;
        @(posedge clk);
        #1;
        rst_x = 1'b1;
        tick(1);
        send_byte(8'h1C);
        tick(1);
        pop_ev(d, ok);
        total_cnt++; if (!ok || d !== 16'h011E) $display("FAIL rs_after got=%h exp=011e", d); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_extended();
        test_pause();
        test_repeat();
        test_back_to_back_full();
        test_timeout();
        test_flush_mid();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
